des_arbiter: RTL
================

# des_arbiter

Shares the single DES round core between the encrypt stream (USB host-to-device) and the decrypt stream (device-to-host). It accepts one 64-bit block at a time from either requester and round-robins between them under contention. It issues the block to the core with the correct direction, waits for completion with a watchdog, and returns the result to the owning requester over a valid/ack handshake. It sits between the two stream FIFO front-ends and the DES core controller.

## Interface
- TIMEOUT, 255: max WAIT_CORE cycles before the block is abandoned (≥2)
- DATA_W, 64: block width
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- req_enc / req_dec  in  1  requester has a block pending; held until granted
- data_enc / data_dec  in  DATA_W  block, valid while req_x high
- gnt_enc / gnt_dec  out  1  block accepted this cycle (Mealy, IDLE only)
- resp_valid_enc / resp_valid_dec  out  1  result available for that requester
- resp_ack_enc / resp_ack_dec  in  1  requester consumed result
- resp_data  out  DATA_W  shared result bus, meaningful while any resp_valid high
- err_enc / err_dec  out  1  one-cycle pulse: owner's block timed out
- des_start  out  1  one-cycle start pulse to core
- des_reverse  out  1  1 = decrypt (reverse key order), held from ISSUE through WAIT_CORE
- des_data_in  out  DATA_W  latched block, stable from ISSUE until next grant
- des_done  in  1  core result valid this cycle
- des_data_out  in  DATA_W  core result

## Operation
- States: IDLE, ISSUE, WAIT_CORE, RESPOND.
- IDLE: if exactly one req_x high, assert gnt_x, latch data_x into the block register, set owner=x, go to ISSUE. If both are high, grant the requester that is not last_owner. With no request, stay in IDLE.
- ISSUE: des_start=1; des_reverse=(owner==DEC); clear the watchdog; go to WAIT_CORE.
- WAIT_CORE: watchdog increments each cycle. On des_done, latch des_data_out into the result register and go to RESPOND. If the count reaches TIMEOUT-1 with no done, go to IDLE and register an err_owner pulse. If done and timeout occur in the same cycle, done wins.
- RESPOND: resp_valid_owner=1 and resp_data=result register. On resp_ack_owner, go to IDLE. Acks from the non-owner are ignored.
- last_owner updates to owner when leaving RESPOND or when a timeout occurs.
- des_done is ignored outside WAIT_CORE.
- A requester dropping req before its grant is not an error; no grant is issued.
- Watchdog width is $clog2(TIMEOUT+1) and it never wraps.

## Timing
- Reset values: state IDLE, last_owner=DEC (so ENC wins the first tie), all outputs 0, block and result registers 0.
- Cycle 0: IDLE with gnt. Cycle 1: ISSUE with des_start. Cycle 2: first WAIT_CORE.
- If des_done arrives in WAIT cycle k (k≥1), resp_valid rises in cycle 2+k. The minimum request-to-resp_valid latency is 3 cycles.
- An ack in the first resp_valid cycle is legal; IDLE follows next cycle, and a new grant is possible in that IDLE cycle.
- Timeout: after TIMEOUT WAIT cycles without done, err_x is high for exactly one cycle, coinciding with the IDLE cycle that follows. A grant may occur in that same cycle.
- Back-to-back throughput: one block per (3 + core latency + ack delay) cycles.
- n_rst asserted mid-operation: immediate return to IDLE with all outputs 0. The in-flight block is dropped and no err is raised.

## Structure
- Shared package des_pkg holds:
  - owner_t enum {OWNER_ENC, OWNER_DEC}
  - arb_state_t enum {IDLE, ISSUE, WAIT_CORE, RESPOND}
  - DES_BLOCK_W = 64
- One sub-module: des_watchdog. It is an up-counter with clear, enable and terminal flag, parameterised by TIMEOUT.

## Test plan
- Single ENC request with data 0x0123456789ABCDEF, core done 3 cycles after start:
  - gnt_enc in cycle 0, des_start in cycle 1, des_reverse=0.
  - resp_valid_enc with the core value in cycle 5; ack clears it next cycle.
- req_enc and req_dec both high from reset:
  - Order ENC, DEC, ENC over three transactions with both held high.
  - des_reverse=1 only for DEC.
- DEC request, core never done, TIMEOUT=4: err_dec is a single pulse 4 cycles after WAIT entry; no resp_valid; next req_enc is granted in the same cycle as err_dec.
- des_done asserted in ISSUE and again in WAIT cycle 1: only the WAIT capture is returned; the ISSUE pulse is ignored.
- In RESPOND for ENC, pulse resp_ack_dec, then resp_ack_enc 2 cycles later: valid persists until resp_ack_enc, then IDLE.
- n_rst low during WAIT_CORE: all outputs 0 immediately; after release, the first tie is granted to ENC.

Source files
------------

// File: rtl/des_pkg.sv
// Shared types and constants for the DES core arbiter.
// Covers the requester identity, the arbiter state encoding and the block width.
package des_pkg;

  localparam int unsigned DES_BLOCK_W = 64;

  typedef enum logic {
    OWNER_ENC = 1'b0,
    OWNER_DEC = 1'b1
  } owner_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_CORE = 2'd2,
    RESPOND   = 2'd3
  } arb_state_t;

  // The requester that is not o; a tie is resolved in its favour.
  function automatic owner_t other_owner(input owner_t o);
    return (o == OWNER_ENC) ? OWNER_DEC : OWNER_ENC;
  endfunction

endpackage

// File: rtl/des_watchdog.sv
// Saturating up-counter with clear, enable and terminal flag.
// The flag rises once the count reaches TIMEOUT-1; the count then holds and never wraps.
module des_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_n_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_term_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TERM_VAL = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != TERM_VAL)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_term_c = (r_count == TERM_VAL);

endmodule

// File: rtl/des_arbiter.sv
// Shares one DES round core between the encrypt and decrypt streams.
// Round-robin grant, single block in flight, watchdog-guarded core wait, valid/ack result return.
module des_arbiter
  import des_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned DATA_W  = DES_BLOCK_W
) (
  input  logic              i_clk,
  input  logic              i_n_rst,
  input  logic              i_req_enc,
  input  logic              i_req_dec,
  input  logic [DATA_W-1:0] i_data_enc,
  input  logic [DATA_W-1:0] i_data_dec,
  output logic              o_gnt_enc,
  output logic              o_gnt_dec,
  output logic              o_resp_valid_enc,
  output logic              o_resp_valid_dec,
  input  logic              i_resp_ack_enc,
  input  logic              i_resp_ack_dec,
  output logic [DATA_W-1:0] o_resp_data,
  output logic              o_err_enc,
  output logic              o_err_dec,
  output logic              o_des_start,
  output logic              o_des_reverse,
  output logic [DATA_W-1:0] o_des_data_in,
  input  logic              i_des_done,
  input  logic [DATA_W-1:0] i_des_data_out
);

  arb_state_t        r_state;
  arb_state_t        w_next_state;
  owner_t            r_owner;
  owner_t            w_next_owner;
  owner_t            r_last_owner;

  logic              w_gnt_enc;
  logic              w_gnt_dec;
  logic              w_wd_clr;
  logic              w_wd_en;
  logic              w_wd_term;
  logic              w_capture;
  logic              w_timeout;
  logic              w_release;
  logic              w_owner_ack;
  logic              w_next_busy;

  logic [DATA_W-1:0] r_block;
  logic [DATA_W-1:0] r_result;
  logic              r_des_start;
  logic              r_des_reverse;
  logic              r_resp_valid_enc;
  logic              r_resp_valid_dec;
  logic              r_err_enc;
  logic              r_err_dec;

  // Only the current owner's ack can close a response.
  assign w_owner_ack = (r_owner == OWNER_ENC) ? i_resp_ack_enc : i_resp_ack_dec;

  des_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .i_clk    (i_clk),
    .i_n_rst  (i_n_rst),
    .i_clr    (w_wd_clr),
    .i_en     (w_wd_en),
    .o_term_c (w_wd_term)
  );

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_owner = r_owner;
    w_gnt_enc    = 1'b0;
    w_gnt_dec    = 1'b0;
    w_wd_clr     = 1'b0;
    w_wd_en      = 1'b0;
    w_capture    = 1'b0;
    w_timeout    = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_req_enc && (!i_req_dec || (other_owner(r_last_owner) == OWNER_ENC))) begin
          w_gnt_enc    = 1'b1;
          w_next_owner = OWNER_ENC;
          w_next_state = ISSUE;
        end else if (i_req_dec) begin
          w_gnt_dec    = 1'b1;
          w_next_owner = OWNER_DEC;
          w_next_state = ISSUE;
        end
      end
      ISSUE: begin
        w_wd_clr     = 1'b1;
        w_next_state = WAIT_CORE;
      end
      WAIT_CORE: begin
        w_wd_en = 1'b1;
        // A done arriving on the terminal cycle still completes the block.
        if (i_des_done) begin
          w_capture    = 1'b1;
          w_next_state = RESPOND;
        end else if (w_wd_term) begin
          w_timeout    = 1'b1;
          w_next_state = IDLE;
        end
      end
      RESPOND: begin
        if (w_owner_ack) begin
          w_release    = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  assign w_next_busy = (w_next_state == ISSUE) || (w_next_state == WAIT_CORE);

  // Datapath and registered outputs, all derived from the upcoming state.
  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      r_owner          <= OWNER_ENC;
      r_last_owner     <= OWNER_DEC;
      r_block          <= '0;
      r_result         <= '0;
      r_des_start      <= 1'b0;
      r_des_reverse    <= 1'b0;
      r_resp_valid_enc <= 1'b0;
      r_resp_valid_dec <= 1'b0;
      r_err_enc        <= 1'b0;
      r_err_dec        <= 1'b0;
    end else begin
      r_owner <= w_next_owner;
      if (w_gnt_enc) begin
        r_block <= i_data_enc;
      end else if (w_gnt_dec) begin
        r_block <= i_data_dec;
      end
      if (w_capture) begin
        r_result <= i_des_data_out;
      end
      if (w_timeout || w_release) begin
        r_last_owner <= r_owner;
      end
      r_des_start      <= (w_next_state == ISSUE);
      r_des_reverse    <= w_next_busy && (w_next_owner == OWNER_DEC);
      r_resp_valid_enc <= (w_next_state == RESPOND) && (w_next_owner == OWNER_ENC);
      r_resp_valid_dec <= (w_next_state == RESPOND) && (w_next_owner == OWNER_DEC);
      r_err_enc        <= w_timeout && (r_owner == OWNER_ENC);
      r_err_dec        <= w_timeout && (r_owner == OWNER_DEC);
    end
  end

  // Grants are Mealy; holding them low during reset keeps every output quiet.
  assign o_gnt_enc        = w_gnt_enc & i_n_rst;
  assign o_gnt_dec        = w_gnt_dec & i_n_rst;
  assign o_resp_valid_enc = r_resp_valid_enc;
  assign o_resp_valid_dec = r_resp_valid_dec;
  assign o_resp_data      = r_result;
  assign o_err_enc        = r_err_enc;
  assign o_err_dec        = r_err_dec;
  assign o_des_start      = r_des_start;
  assign o_des_reverse    = r_des_reverse;
  assign o_des_data_in    = r_block;

endmodule
